// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: resets the PLL, waits for a stable lock, then releases the core reset.
// Define PLL_SUPERVISOR_GLITCH_FILTER_EN to ignore dropouts shorter than GLITCH_CYCLES in RUN.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 4096,
  parameter int GLITCH_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             locked_async,
  input  logic             clr_sticky,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [1:0]       state,
  output logic             lost_lock,
  output logic [CNT_W-1:0] unlock_cnt
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int MAX_AB   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_WAIT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 ||
      GLITCH_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
    $error("pll_lock_supervisor: parameter out of range");
  end

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [1:0]         sync_reg;
  logic               locked_s;
  logic               loss;
  logic               pll_rst_reg, pll_rst_next;
  logic               run_reg, run_next;
  logic               lost_lock_reg, lost_lock_next;
  logic [CNT_W-1:0]   unlock_cnt_reg, unlock_cnt_next;

  // Only sync_reg[0] ever sees the asynchronous lock signal.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b00;
    else        sync_reg <= {sync_reg[0], locked_async};
  end
  assign locked_s = sync_reg[1];

`ifdef PLL_SUPERVISOR_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  logic [GW-1:0] glitch_reg, glitch_next;

  // Counts consecutive low samples in RUN; any high sample restarts it.
  always_comb begin
    glitch_next = '0;
    loss        = 1'b0;
    if (state_reg == RUN && !locked_s) begin
      if (glitch_reg == GW'(GLITCH_CYCLES - 1)) loss = 1'b1;
      else glitch_next = glitch_reg + GW'(1);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) glitch_reg <= '0;
    else        glitch_reg <= glitch_next;
  end
`else
  assign loss = (state_reg == RUN) && !locked_s;
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RESET_PLL: if (cnt_reg == RST_LAST) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s)                   state_next = STABLE;
        else if (cnt_reg == TMO_LAST)   state_next = RESET_PLL;
      end
      STABLE: begin
        if (!locked_s)                  state_next = WAIT_LOCK;
        else if (cnt_reg == STABLE_LAST) state_next = RUN;
      end
      RUN:       if (loss) state_next = RESET_PLL;
      default:   state_next = RESET_PLL;
    endcase

    cnt_next     = (state_next != state_reg) ? '0 : cnt_reg + CW'(1);
    pll_rst_next = (state_next == RESET_PLL);
    run_next     = (state_next == RUN);
  end

  // A loss coinciding with a clear is still recorded, as the first of a fresh count.
  always_comb begin
    lost_lock_next  = lost_lock_reg;
    unlock_cnt_next = unlock_cnt_reg;
    if (loss) begin
      lost_lock_next = 1'b1;
      if (clr_sticky)
        unlock_cnt_next = CNT_W'(1);
      else if (unlock_cnt_reg != {CNT_W{1'b1}})
        unlock_cnt_next = unlock_cnt_reg + CNT_W'(1);
    end else if (clr_sticky) begin
      lost_lock_next  = 1'b0;
      unlock_cnt_next = '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RESET_PLL;
      cnt_reg        <= '0;
      pll_rst_reg    <= 1'b1;
      run_reg        <= 1'b0;
      lost_lock_reg  <= 1'b0;
      unlock_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pll_rst_reg    <= pll_rst_next;
      run_reg        <= run_next;
      lost_lock_reg  <= lost_lock_next;
      unlock_cnt_reg <= unlock_cnt_next;
    end
  end

  assign pll_rst    = pll_rst_reg;
  assign sys_rst_n  = run_reg;
  assign ready      = run_reg;
  assign state      = state_reg;
  assign lost_lock  = lost_lock_reg;
  assign unlock_cnt = unlock_cnt_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: table of startup/dropout steps plus hand sequences
// for timeout, STABLE dropout, async reset, counter saturation and clear-vs-loss.
module tb_pll_lock_supervisor;
  localparam int RSTC = 4;
  localparam int TMO  = 8;
  localparam int STC  = 6;
  localparam int GLC  = 3;
  localparam int CW   = 8;
`ifdef PLL_SUPERVISOR_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int LOSS_LAT = FILT ? (2 + GLC) : 3;

  logic          refclk;
  logic          rst_n;
  logic          locked_async;
  logic          clr_sticky;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          ready;
  logic [1:0]    state;
  logic          lost_lock;
  logic [CW-1:0] unlock_cnt;

  int tests  = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STC),
    .GLITCH_CYCLES(GLC), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .locked_async(locked_async),
    .clr_sticky(clr_sticky), .pll_rst(pll_rst), .sys_rst_n(sys_rst_n),
    .ready(ready), .state(state), .lost_lock(lost_lock), .unlock_cnt(unlock_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic lock;
    logic clr;
    int   n;
    int   st;
    logic pll;
    logic sys;
    logic lost;
    int   ucnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int pll,
                           input int sys, input int lost, input int ucnt);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".pll_rst"}, int'(pll_rst), pll);
    check({tag, ".sys_rst_n"}, int'(sys_rst_n), sys);
    check({tag, ".ready"}, int'(ready), sys);
    check({tag, ".lost_lock"}, int'(lost_lock), lost);
    check({tag, ".unlock_cnt"}, int'(unlock_cnt), ucnt);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k = 0;
    while (int'(state) != s && k < budget) begin
      tick(1);
      k++;
    end
    check(name, int'(state), s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    locked_async = 1'b1;
    clr_sticky   = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 3,  0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1,  1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 1,  2, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 5,  2, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b0, 1,  3, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b0, 4,  3, 1'b0, 1'b1, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b0, 2,  3, 1'b0, 1'b1, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b0, 1,  FILT ? 3 : 0, !FILT, FILT, !FILT, FILT ? 0 : 1};
    vecs[8] = '{1'b1, 1'b0, 11, 3, 1'b0, 1'b1, !FILT, FILT ? 0 : 1};

    // Reset values
    tick(2);
    check_all("reset", 0, 1, 0, 0, 0);

    // Startup with lock held, then a 2-cycle dropout in RUN
    @(posedge refclk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      locked_async = vecs[i].lock;
      clr_sticky   = vecs[i].clr;
      tick(vecs[i].n);
      $display("[TB] vec %0d lock=%0b n=%0d -> state=%0d sys_rst_n=%0b unlock_cnt=%0d",
               i, vecs[i].lock, vecs[i].n, state, sys_rst_n, unlock_cnt);
      check_all($sformatf("vec%0d", i), vecs[i].st, int'(vecs[i].pll), int'(vecs[i].sys),
                int'(vecs[i].lost), vecs[i].ucnt);
    end

    // Asynchronous reset in RUN, observed before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 1, 0, 0, 0);

    // Lock never arrives: RESET_PLL(4) / WAIT_LOCK(8) forever
    @(posedge refclk); #1;
    locked_async = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      int exp_st;
      tick(1);
      exp_st = ((k % (RSTC + TMO)) < RSTC) ? 0 : 1;
      check_all($sformatf("timeout_e%0d", k), exp_st, (exp_st == 0) ? 1 : 0, 0, 0, 0);
    end
    $display("[TB] timeout sequence done, state=%0d", state);

    // One-sample dropout in STABLE at cnt=3: back to WAIT_LOCK without a PLL reset
    #2;
    rst_n = 1'b0;
    @(posedge refclk); #1;
    locked_async = 1'b1;
    rst_n = 1'b1;
    tick(4); check_all("stab_e4", 1, 0, 0, 0, 0);
    tick(1); check_all("stab_e5", 2, 0, 0, 0, 0);
    tick(1); locked_async = 1'b0;
    tick(1); locked_async = 1'b1;
    tick(1); check_all("stab_e8", 2, 0, 0, 0, 0);
    tick(1); check_all("stab_e9", 1, 0, 0, 0, 0);
    tick(1); check_all("stab_e10", 2, 0, 0, 0, 0);
    tick(5); check_all("stab_e15", 2, 0, 0, 0, 0);
    tick(1); check_all("stab_e16", 3, 0, 1, 0, 0);
    $display("[TB] stable dropout sequence done, state=%0d", state);

    // 257 losses saturate the 8-bit counter
    for (int i = 1; i <= 257; i++) begin
      wait_state(3, 40, "sat_wait_run");
      locked_async = 1'b0;
      wait_state(0, 20, "sat_wait_loss");
      locked_async = 1'b1;
      if (i == 1)   check("sat_cnt_1", int'(unlock_cnt), 1);
      if (i == 255) check("sat_cnt_255", int'(unlock_cnt), 255);
    end
    check("sat_cnt_257", int'(unlock_cnt), 255);
    check("sat_lost", int'(lost_lock), 1);
    $display("[TB] saturation sequence done, unlock_cnt=%0d", unlock_cnt);

    // Clear on the exact edge a loss is declared: the loss wins
    wait_state(3, 40, "clr_wait_run");
    locked_async = 1'b0;
    tick(LOSS_LAT - 1);
    check("clr_pre_loss_state", int'(state), 3);
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    check_all("clr_vs_loss", 0, 1, 0, 1, 1);
    locked_async = 1'b1;

    // Clear on its own
    tick(1);
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    check("clr_only_lost", int'(lost_lock), 0);
    check("clr_only_cnt", int'(unlock_cnt), 0);
    $display("[TB] clear sequence done, lost_lock=%0b unlock_cnt=%0d", lost_lock, unlock_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the lock status of a clock PLL and sequences system reset around it. Runs on the free-running board reference clock, synchronizes the PLL's asynchronous `locked` output, pulses the PLL reset on start-up and on lock timeout, and releases `sys_rst_n` only after lock has been stable for a programmable interval. It sits between the PLL instance and the core's reset tree, and reports lock-loss events to the OSD/status logic.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before re-resetting the PLL (≥2).
- `STABLE_CYCLES`, 4096: consecutive locked cycles required before reset release (≥1).
- `GLITCH_CYCLES`, 4: consecutive unlocked samples that constitute a loss in RUN (≥1; used only with filter).
- `CNT_W`, 8: width of the unlock event counter.

- `refclk` in 1: free-running reference clock (50 MHz); all logic on its rising edge.
- `rst_n` in 1: asynchronous active-low reset; asynchronous assert, synchronous deassert is the caller's job.
- `locked_async` in 1: PLL lock indicator, asynchronous to `refclk`.
- `clr_sticky` in 1: synchronous clear of `lost_lock` and `unlock_cnt`.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_rst_n` out 1: active-low reset to the core; high only in RUN.
- `ready` out 1: high in RUN.
- `state` out 2: current state encoding.
- `lost_lock` out 1: sticky, set on any loss in RUN.
- `unlock_cnt` out CNT_W: saturating count of losses in RUN.

## Operation
- `locked_async` passes through a 2-flop synchronizer → `locked_s`. No other logic samples `locked_async`.
- One cycle counter `cnt`, cleared on every state entry, counts cycles spent in the current state.
- States (encoding): RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3.
- RESET_PLL: `pll_rst`=1. When `cnt`==RST_CYCLES-1 → WAIT_LOCK.
- WAIT_LOCK: if `locked_s` → STABLE; else if `cnt`==LOCK_TIMEOUT-1 → RESET_PLL. Retries are unlimited.
- STABLE: if `!locked_s` → WAIT_LOCK (no PLL reset, counter restarts); else if `cnt`==STABLE_CYCLES-1 → RUN.
- RUN: on loss detection → RESET_PLL, `lost_lock`←1, `unlock_cnt`←`unlock_cnt`+1 saturating at all-ones.
- Losses outside RUN do not touch `lost_lock`/`unlock_cnt`.
- `clr_sticky` clears `lost_lock` and `unlock_cnt`; a loss on the same cycle wins: `lost_lock`=1, `unlock_cnt`=1.
- All outputs are registered and change on the same edge as `state`; `pll_rst`=(state==RESET_PLL), `sys_rst_n`=`ready`=(state==RUN).

## Timing
- Reset values: `state`=RESET_PLL, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `lost_lock`=0, `unlock_cnt`=0, `cnt`=0, synchronizer flops=0.
- Reset asserted mid-operation: immediate return to reset values regardless of state; `pll_rst` rises asynchronously.
- After `rst_n` deassert: `pll_rst` high for exactly RST_CYCLES edges.
- `locked_async` rising (held) in WAIT_LOCK at edge 0: `locked_s` high after edge 2, STABLE at edge 3, RUN/`sys_rst_n`=1 at edge 3+STABLE_CYCLES.
- Loss in RUN: `locked_async` falls before edge 0 → RESET_PLL, `sys_rst_n`=0 at edge 3 (no filter) or edge 2+GLITCH_CYCLES (filter).
- Timeout: with `locked_s` low, WAIT_LOCK lasts exactly LOCK_TIMEOUT cycles.

## Configuration
- `PLL_SUPERVISOR_GLITCH_FILTER_EN` defined: in RUN, a loss is declared only after GLITCH_CYCLES consecutive low `locked_s` samples; any high sample clears the glitch counter. Shorter dropouts are ignored entirely (no flag, no count).
- Not defined: a single low `locked_s` sample in RUN is a loss; GLITCH_CYCLES is unused and the glitch counter is not built.

## Test plan
(RST_CYCLES=4, LOCK_TIMEOUT=8, STABLE_CYCLES=6, GLITCH_CYCLES=3)
- Reset release, `locked_async` tied 1 → `pll_rst` high 4 cycles, STABLE 1 cycle later, `sys_rst_n`=1 six cycles after STABLE entry, `unlock_cnt`=0.
- `locked_async` tied 0 → `state` cycles RESET_PLL(4)/WAIT_LOCK(8) repeatedly, `sys_rst_n` never 1, `lost_lock`=0.
- Lock then drop for 1 cycle in STABLE at `cnt`=3 → back to WAIT_LOCK, re-enter STABLE, RUN 6 cycles after re-entry; no PLL reset pulse.
- In RUN, 2-cycle dropout → filter on: stays RUN, `unlock_cnt`=0; filter off: RESET_PLL at edge 3, `lost_lock`=1, `unlock_cnt`=1.
- 257 losses with CNT_W=8 → `unlock_cnt`=255; then `clr_sticky` coinciding with a loss → `lost_lock`=1, `unlock_cnt`=1.
- `rst_n` pulsed low during RUN → `sys_rst_n`=0 and `pll_rst`=1 immediately, counters cleared.
